// File: rtl/out_arb_pkg.sv
// Shared definitions for the output-port arbiter: port count, flit flow
// encodings, arbiter state enum and the ASSERT/NEGATE logic constants.
package out_arb_pkg;

  // Highest input port index; an output port arbitrates among PORT+1 inputs.
  localparam int unsigned PORT = 3;

  // Width of the crossbar select / granted-index field.
  localparam int unsigned SELW = 2;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  // Flow bits carried with the head flit of each input buffer.
  localparam logic [1:0] EMPT = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] HEAD = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

endpackage

// File: rtl/out_arb_rr_pick.sv
// Rotating priority encoder: scans req starting at index ptr and returns the
// first requester found.
//   req  - request vector, bit i = input i
//   ptr  - index where the search starts (tie to 0 for fixed priority)
//   gnt  - one-hot grant, all-zero when no request
//   idx  - binary index of the granted input
//   any  - at least one request present
module out_arb_rr_pick
  import out_arb_pkg::*;
#(
  parameter int unsigned NPORT = PORT + 1
) (
  input  logic [NPORT-1:0] req,
  input  logic [SELW-1:0]  ptr,
  output logic [NPORT-1:0] gnt,
  output logic [SELW-1:0]  idx,
  output logic             any
);

  logic [SELW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = NEGATE;
    cand = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      cand = SELW'((32'(ptr) + i) % NPORT);
      if (!any && req[cand]) begin
        any       = ASSERT;
        gnt[cand] = ASSERT;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/out_arb.sv
// Output-port arbiter. Grants one input port at a time and holds the grant
// for a whole packet (HEAD..TAIL), releasing only on TAIL transfer or reset.
// Define OUT_ARB_RR_EN for round-robin arbitration; otherwise the lowest
// requesting index always wins.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   req   - per-input request for this output
//   flowi - head-flit flow bits, input i at [2i+1:2i]
//   full  - downstream buffer full, blocks transfers
//   ack   - one-hot read strobe to the granted input
//   sel   - crossbar select (granted index)
//   wen   - write enable into the output buffer
//   busy  - a packet currently holds the output
module out_arb
  import out_arb_pkg::*;
#(
  parameter int unsigned NPORT = PORT + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPORT-1:0]   req,
  input  logic [2*NPORT-1:0] flowi,
  input  logic               full,
  output logic [NPORT-1:0]   ack,
  output logic [SELW-1:0]    sel,
  output logic               wen,
  output logic               busy
);

  state_e           state_q, state_d;
  logic [SELW-1:0]  g_q, g_d;
  logic [NPORT-1:0] oh_q, oh_d;
  logic [SELW-1:0]  ptr;
  logic [NPORT-1:0] pick_gnt;
  logic [SELW-1:0]  pick_idx;
  logic             pick_any;
  logic [1:0]       flow_g;
  logic             xfer;
  logic             tail_done;

  out_arb_rr_pick #(
    .NPORT(NPORT)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  assign flow_g    = flowi[{g_q, 1'b0} +: 2];
  assign xfer      = (state_q == LOCK) && !full && (flow_g != EMPT);
  assign tail_done = xfer && (flow_g == TAIL);

`ifdef OUT_ARB_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;

  // Next search starts just past the port that finished its packet.
  always_comb begin
    ptr_d = ptr_q;
    if (tail_done) begin
      ptr_d = SELW'((32'(g_q) + 1) % NPORT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    oh_d    = oh_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCK;
          g_d     = pick_idx;
          oh_d    = pick_gnt;
        end
      end
      LOCK: begin
        // Request deassertion does not release the lock; only TAIL does.
        if (tail_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      oh_q    <= oh_d;
    end
  end

  assign busy = (state_q == LOCK) ? ASSERT : NEGATE;
  assign ack  = (busy && !full) ? oh_q : '0;
  assign sel  = g_q;
  assign wen  = xfer;

endmodule

// File: tb/tb_out_arb.sv
module tb_out_arb;

  localparam int NP = 4;
  localparam logic [1:0] F_EMPT = 2'b00;
  localparam logic [1:0] F_BODY = 2'b01;
  localparam logic [1:0] F_HEAD = 2'b10;
  localparam logic [1:0] F_TAIL = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req;
  logic [2*NP-1:0] flowi;
  logic          full;
  logic [NP-1:0] ack;
  logic [1:0]    sel;
  logic          wen;
  logic          busy;

  out_arb #(
    .NPORT(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .flowi(flowi),
    .full(full),
    .ack(ack),
    .sel(sel),
    .wen(wen),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-port packet lengths and flit queues (what each input buffer holds).
  int         pl[NP][$];
  logic [1:0] fq[NP][$];
  bit         started[NP];

  // Scoreboard: expected (port, flow) of each transferred flit, in order.
  int         sb_port[$];
  logic [1:0] sb_flow[$];

  bit mon_en   = 1'b0;
  bit xfer_pend = 1'b0;
  int xfer_port = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] flit_of(input int len, input int k);
    if (k == len - 1) return F_TAIL;
    if (k == 0) return F_HEAD;
    return F_BODY;
  endfunction

  // Packet-level reference: whole packets are serviced back to back, the
  // winner chosen among ports that still hold packets.
  task automatic build_model();
    int nxt[NP];
    int ptr;
    int left;
    int w;
    int c;
    int len;
    ptr  = 0;
    left = 0;
    for (int i = 0; i < NP; i++) begin
      nxt[i] = 0;
      left += pl[i].size();
    end
    while (left > 0) begin
      w = -1;
      for (int off = 0; off < NP; off++) begin
`ifdef OUT_ARB_RR_EN
        c = (ptr + off) % NP;
`else
        c = off;
`endif
        if (w < 0 && nxt[c] < pl[c].size()) w = c;
      end
      len = pl[w][nxt[w]];
      for (int k = 0; k < len; k++) begin
        sb_port.push_back(w);
        sb_flow.push_back(flit_of(len, k));
      end
      nxt[w]++;
      left--;
      ptr = (w + 1) % NP;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [2*NP-1:0] sh;
      int ep;
      logic [1:0] ef;
      chk("ack_onehot", int'($countones(ack) <= 1), 1);
      if (busy && !full) chk("ack_in_lock", int'(ack != '0), 1);
      if (wen) begin
        if (sb_port.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: unexpected transfer from port %0d, expected none", sel);
        end else begin
          ep = sb_port.pop_front();
          ef = sb_flow.pop_front();
          sh = flowi >> (2 * int'(sel));
          chk("xfer_port", int'(sel), ep);
          chk("xfer_flow", int'(sh[1:0]), int'(ef));
          chk("xfer_ack", int'(ack), 1 << ep);
          chk("xfer_full", int'(full), 0);
        end
        xfer_pend = 1'b1;
        xfer_port = int'(sel);
      end
    end
  end

  initial begin
    int len;
    logic [NP-1:0] r;
    logic [2*NP-1:0] fv;
    logic [1:0] f;
    rst   = 1'b1;
    req   = '0;
    flowi = '0;
    full  = 1'b0;

    // Reset state after two reset cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wen", int'(wen), 0);
    rst = 1'b0;

    // Random traffic: 2..5 packets of 1..4 flits per port.
    for (int i = 0; i < NP; i++) begin
      started[i] = 1'b0;
      for (int p = 0; p < 2 + int'($urandom_range(3)); p++) begin
        len = 1 + int'($urandom_range(3));
        pl[i].push_back(len);
        for (int k = 0; k < len; k++) fq[i].push_back(flit_of(len, k));
      end
    end
    build_model();
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 20000 && sb_port.size() > 0; cyc++) begin
      @(posedge clk);
      #1;
      if (xfer_pend) begin
        f = fq[xfer_port].pop_front();
        started[xfer_port] = (f != F_TAIL);
        xfer_pend = 1'b0;
      end
      full = ($urandom_range(3) == 0);
      r  = '0;
      fv = '0;
      for (int i = 0; i < NP; i++) begin
        if (fq[i].size() > 0) begin
          // A port already mid-packet may drop req without losing the lock.
          if (!(started[i] && $urandom_range(2) == 0)) r = r | (NP'(1) << i);
          if ($urandom_range(4) != 0) fv = fv | ((2*NP)'(fq[i][0]) << (2 * i));
        end
      end
      req   = r;
      flowi = fv;
    end
    mon_en = 1'b0;
    chk("random_drain", sb_port.size(), 0);

    // Let the final TAIL go through, then quiesce.
    @(posedge clk);
    #1;
    req   = '0;
    flowi = '0;
    full  = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    // Single packet on port 2: grant one cycle after request.
    req   = 4'b0100;
    flowi = 8'h20;  // port 2 HEAD
    @(posedge clk);
    #1;
    chk("p2_ack", int'(ack), 4);
    chk("p2_sel", int'(sel), 2);
    chk("p2_busy", int'(busy), 1);
    chk("p2_wen_head", int'(wen), 1);
    flowi = 8'h10;  // port 2 BODY
    @(posedge clk);
    #1;
    chk("p2_wen_body", int'(wen), 1);

    // Reset during BODY aborts the lock and clears the pointer.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_wen", int'(wen), 0);
    rst   = 1'b0;
    req   = 4'b1111;
    flowi = 8'hFF;  // single-flit TAIL packets everywhere
    @(posedge clk);
    #1;
    chk("post_rst_sel", int'(sel), 0);
    chk("post_rst_ack", int'(ack), 1);
    @(posedge clk);
    #1;
    chk("tail_release_busy", int'(busy), 0);
    chk("tail_release_ack", int'(ack), 0);
    @(posedge clk);
    #1;
`ifdef OUT_ARB_RR_EN
    chk("second_grant", int'(sel), 1);
`else
    chk("second_grant", int'(sel), 0);
`endif
    chk("second_busy", int'(busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
